// File: rtl/prio_event_encoder.sv
// prio_event_encoder: edge/level event capture into a pending register, masked
// fixed-priority or round-robin arbitration, and a registered valid/ack output.
module prio_event_encoder #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         edge_mode,
    input  logic         rr_mode,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    input  logic         ack,
    output logic [N-1:0] pending,
    output logic         overflow
);
    logic [N-1:0] req_q, set_v, clear_v, elig;
    logic [W-1:0] ptr, start, winner;
    logic         xfer, load, any;
    int           idx;

    // The search start is the pointer as updated by this cycle's transfer; the
    // loop runs from the lowest search priority up so the last hit wins.
    always_comb begin
        xfer    = out_valid & ack;
        set_v   = (en & ~clr) ? (edge_mode ? req & ~req_q : req) : '0;
        clear_v = xfer ? N'(1) << out_code : '0;
        elig    = pending & ~clear_v & ~mask;
        any     = |elig;
        load    = en & (~out_valid | xfer);
        start   = rr_mode ? (xfer ? out_code : ptr) : '0;
        winner  = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(start) >= k) ? int'(start) - k : int'(start) + N - k;
            if (elig[idx]) winner = W'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= '0;
            ptr       <= '0;
        end else begin
            req_q <= req;
            if (clr) begin
                pending   <= '0;
                overflow  <= 1'b0;
                out_valid <= 1'b0;
                out_code  <= '0;
                ptr       <= '0;
            end else begin
                pending  <= (pending & ~clear_v) | set_v;
                overflow <= overflow | (edge_mode & |(set_v & pending & ~clear_v));
                if (xfer) ptr <= out_code;
                if (!en) begin
                    out_valid <= 1'b0;
                end else if (load) begin
                    out_valid <= any;
                    if (any) out_code <= winner;
                end
            end
        end
    end
endmodule

// File: tb/tb_prio_event_encoder.sv
// tb_prio_event_encoder: directed vector table for N=8 plus hand-written
// sequences for async reset and round-robin wrap with non-power-of-two N=5.
module tb_prio_event_encoder;
    logic       clk = 0, rst_n = 0;
    logic       en = 0, clr = 0, edge_mode = 0, rr_mode = 0, ack = 0;
    logic [7:0] req = 0, mask = 0, pending;
    logic       out_valid, overflow;
    logic [2:0] out_code;

    logic       b_en = 1, b_clr = 0, b_em = 0, b_rr = 1, b_ack = 1;
    logic [4:0] b_req = 0, b_mask = 0, b_pending;
    logic       b_valid, b_overflow;
    logic [2:0] b_code;

    int n_vec = 0, n_bad = 0;

    typedef struct {
        logic       en, clr, em, rr;
        logic [7:0] req, mask;
        logic       ack;
        logic       ov;
        logic [2:0] code;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    prio_event_encoder #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .edge_mode(edge_mode),
        .rr_mode(rr_mode), .req(req), .mask(mask), .out_valid(out_valid),
        .out_code(out_code), .ack(ack), .pending(pending), .overflow(overflow)
    );

    prio_event_encoder #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr), .edge_mode(b_em),
        .rr_mode(b_rr), .req(b_req), .mask(b_mask), .out_valid(b_valid),
        .out_code(b_code), .ack(b_ack), .pending(b_pending), .overflow(b_overflow)
    );

    task automatic add(input logic e, c, em, rr, input logic [7:0] rq, mk, input logic a,
                       input logic ov, input logic [2:0] cd, input logic [7:0] pd, input logic of);
        vq.push_back('{e, c, em, rr, rq, mk, a, ov, cd, pd, of});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int exp5[6] = '{4, 3, 2, 1, 0, 4};
        //  en clr em rr req    mask   ack | ov code pend   ovf
        // fixed priority, edge mode, one pulse of A4
        add(1, 0, 1, 0, 8'hA4, 8'h00, 0,  0, 0, 8'hA4, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0,  1, 7, 8'hA4, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  1, 5, 8'h24, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  1, 2, 8'h04, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  0, 2, 8'h00, 0);
        add(1, 1, 1, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0);
        // round-robin, level mode, all requests held with ack
        add(1, 0, 0, 1, 8'hFF, 8'h00, 1,  0, 0, 8'hFF, 0);
        add(1, 0, 0, 1, 8'hFF, 8'h00, 1,  1, 7, 8'hFF, 0);
        for (int i = 6; i >= 0; i--) add(1, 0, 0, 1, 8'hFF, 8'h00, 1, 1, 3'(i), 8'hFF, 0);
        add(1, 0, 0, 1, 8'hFF, 8'h00, 1,  1, 7, 8'hFF, 0);
        add(1, 1, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0);
        // overflow on a masked line, then single grant, then clr
        add(1, 0, 1, 0, 8'h08, 8'h08, 0,  0, 0, 8'h08, 0);
        add(1, 0, 1, 0, 8'h00, 8'h08, 0,  0, 0, 8'h08, 0);
        add(1, 0, 1, 0, 8'h08, 8'h08, 0,  0, 0, 8'h08, 1);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0,  1, 3, 8'h08, 1);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  0, 3, 8'h00, 1);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0,  0, 3, 8'h00, 1);
        add(1, 1, 1, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0);
        // hold without preemption
        add(1, 0, 1, 0, 8'h04, 8'h00, 0,  0, 0, 8'h04, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0,  1, 2, 8'h04, 0);
        add(1, 0, 1, 0, 8'h80, 8'h00, 0,  1, 2, 8'h84, 0);
        add(1, 0, 1, 0, 8'h80, 8'h00, 0,  1, 2, 8'h84, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  1, 7, 8'h80, 0);
        add(1, 0, 1, 0, 8'h00, 8'h00, 1,  0, 7, 8'h00, 0);
        // level mode: set wins over clear on the acked bit
        add(1, 0, 0, 0, 8'h10, 8'h00, 0,  0, 7, 8'h10, 0);
        add(1, 0, 0, 0, 8'h10, 8'h00, 0,  1, 4, 8'h10, 0);
        add(1, 0, 0, 0, 8'h10, 8'h00, 1,  0, 4, 8'h10, 0);
        add(1, 0, 0, 0, 8'h00, 8'h00, 0,  1, 4, 8'h10, 0);
        add(1, 0, 0, 0, 8'h00, 8'h00, 1,  0, 4, 8'h00, 0);
        // enable drop and re-enable with a held request
        add(1, 0, 1, 0, 8'h02, 8'h00, 0,  0, 4, 8'h02, 0);
        add(1, 0, 1, 0, 8'h02, 8'h00, 0,  1, 1, 8'h02, 0);
        add(0, 0, 1, 0, 8'h02, 8'h00, 0,  0, 1, 8'h02, 0);
        add(0, 0, 1, 0, 8'h42, 8'h00, 1,  0, 1, 8'h02, 0);
        add(1, 0, 1, 0, 8'h42, 8'h00, 0,  1, 1, 8'h02, 0);

        #12;
        chk("reset", {out_valid, out_code, pending, overflow}, 32'h0);
        @(negedge clk) rst_n = 1;
        foreach (vq[i]) begin
            en = vq[i].en; clr = vq[i].clr; edge_mode = vq[i].em; rr_mode = vq[i].rr;
            req = vq[i].req; mask = vq[i].mask; ack = vq[i].ack;
            @(posedge clk); #1;
            chk($sformatf("v%0d {ov,code,pend,ovf}", i), {out_valid, out_code, pending, overflow},
                {vq[i].ov, vq[i].code, vq[i].pend, vq[i].ovf});
        end

        // asynchronous reset while a code is presented
        rst_n = 0;
        #1;
        chk("async_reset", {out_valid, out_code, pending, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        req = 0; ack = 0;

        // N=5 round-robin wraps 0 -> 4
        b_req = 5'h1F;
        @(posedge clk); #1;
        chk("n5_capture", {b_valid, b_pending}, {1'b0, 5'h1F});
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("n5_rr%0d", i), {b_valid, b_code}, {1'b1, 3'(exp5[i])});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
